// File: rtl/command_executor_pkg.sv
// command_executor_pkg: shared command/parameter types and executor state encoding
package command_executor_pkg;
   localparam logic [7:0] BLANK_CHAR = 8'h20;
   typedef enum logic [3:0] {INPUT, CUU, CUD, CUF, CUB, CUP, IND, NEL, RI} CommandsType;
   typedef struct packed {
      logic [7:0] Pchar;
      logic [7:0] Pn1;
      logic [7:0] Pn2;
   } Param_t;
   typedef enum logic [1:0] {INIT, IDLE, CLEAR} ExecState;
endpackage

// File: rtl/command_executor_row_mapper.sv
// row_mapper: logical (top_row, y, x) to physical text-RAM cell address
module row_mapper #(
   parameter int COLS = 80,
   parameter int ROWS = 25,
   localparam int XW = $clog2(COLS),
   localparam int YW = $clog2(ROWS),
   localparam int AW = $clog2(COLS*ROWS)
) (
   input  logic [YW-1:0] top_row,
   input  logic [YW-1:0] y,
   input  logic [XW-1:0] x,
   output logic [AW-1:0] addr
);
   logic [YW:0] sum, phys;
   always_comb begin
      sum = {1'b0, top_row} + {1'b0, y};
      phys = (sum >= (YW+1)'(ROWS)) ? sum - (YW+1)'(ROWS) : sum;
      addr = AW'(phys) * AW'(COLS) + AW'(x);
   end
endmodule

// File: rtl/command_executor.sv
// command_executor: executes parsed terminal commands against the text RAM, owning cursor and scroll origin
module command_executor
   import command_executor_pkg::*;
#(
   parameter int COLS = 80,
   parameter int ROWS = 25,
   parameter logic [7:0] BLANK = BLANK_CHAR,
   localparam int XW = $clog2(COLS),
   localparam int YW = $clog2(ROWS),
   localparam int AW = $clog2(COLS*ROWS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          commandReady,
   input  CommandsType   commandType,
   input  Param_t        param,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_wdata,
   output logic [XW-1:0] cursor_x,
   output logic [YW-1:0] cursor_y,
   output logic [YW-1:0] top_row,
   output logic          busy,
   output logic          overflow
);
   ExecState state;
   logic pend_v, go, store, lf, rev, up, down;
   CommandsType pend_cmd, cmd;
   Param_t pend_par, par;
   logic [AW-1:0] cnt, cur_addr, clr_addr;
   logic [YW-1:0] clr_row, top_inc, top_dec;
   int n, row, col, nx, ny;

   row_mapper #(.COLS(COLS), .ROWS(ROWS)) u_cur (.top_row(top_row), .y(cursor_y), .x(cursor_x), .addr(cur_addr));
   row_mapper #(.COLS(COLS), .ROWS(ROWS)) u_clr (.top_row(clr_row), .y('0), .x(cnt[XW-1:0]), .addr(clr_addr));

   // The pending slot always wins over the live input once we are back in IDLE
   always_comb begin
      cmd = pend_v ? pend_cmd : commandType;
      par = pend_v ? pend_par : param;
      go = (state == IDLE) && (pend_v || commandReady);
      n = (par.Pn1 == 8'd0) ? 1 : int'(par.Pn1);
      row = (par.Pn1 == 8'd0) ? 1 : (int'(par.Pn1) > ROWS) ? ROWS : int'(par.Pn1);
      col = (par.Pn2 == 8'd0) ? 1 : (int'(par.Pn2) > COLS) ? COLS : int'(par.Pn2);
      nx = int'(cursor_x);
      ny = int'(cursor_y);
      store = 1'b0;
      lf = 1'b0;
      rev = 1'b0;
      case (cmd)
         INPUT:
            if (par.Pchar >= 8'h20 && par.Pchar <= 8'h7E) begin
               store = 1'b1;
               lf = (nx == COLS-1);
               nx = lf ? 0 : nx + 1;
            end else if (par.Pchar == 8'h0D) nx = 0;
            else if (par.Pchar == 8'h0A) lf = 1'b1;
            else if (par.Pchar == 8'h08) nx = (nx > 0) ? nx - 1 : 0;
         CUU: ny = (ny > n) ? ny - n : 0;
         CUD: ny = (ny + n > ROWS-1) ? ROWS-1 : ny + n;
         CUF: nx = (nx + n > COLS-1) ? COLS-1 : nx + n;
         CUB: nx = (nx > n) ? nx - n : 0;
         CUP: begin
            ny = row - 1;
            nx = col - 1;
         end
         IND: lf = 1'b1;
         NEL: begin
            lf = 1'b1;
            nx = 0;
         end
         RI: rev = 1'b1;
         default: ;
      endcase
      up = lf && (ny == ROWS-1);
      down = rev && (ny == 0);
      ny = (lf && !up) ? ny + 1 : (rev && !down) ? ny - 1 : ny;
      top_inc = (top_row == YW'(ROWS-1)) ? '0 : top_row + 1'b1;
      top_dec = (top_row == '0) ? YW'(ROWS-1) : top_row - 1'b1;
   end

   always_ff @(posedge clk)
      if (rst) begin
         state <= INIT;
         cursor_x <= '0;
         cursor_y <= '0;
         top_row <= '0;
         clr_row <= '0;
         cnt <= '0;
         ram_we <= 1'b0;
         ram_addr <= '0;
         ram_wdata <= BLANK;
         busy <= 1'b1;
         overflow <= 1'b0;
         pend_v <= 1'b0;
         pend_cmd <= INPUT;
         pend_par <= '0;
      end else begin
         ram_we <= 1'b0;
         if (state != IDLE) begin
            if (commandReady && pend_v) overflow <= 1'b1;
            else if (commandReady) begin
               pend_v <= 1'b1;
               pend_cmd <= commandType;
               pend_par <= param;
            end
         end else if (pend_v) begin
            pend_v <= commandReady;
            pend_cmd <= commandType;
            pend_par <= param;
         end
         case (state)
            INIT: begin
               ram_we <= 1'b1;
               ram_addr <= cnt;
               ram_wdata <= BLANK;
               cnt <= (cnt == AW'(COLS*ROWS-1)) ? '0 : cnt + 1'b1;
               state <= (cnt == AW'(COLS*ROWS-1)) ? IDLE : INIT;
            end
            CLEAR: begin
               ram_we <= 1'b1;
               ram_addr <= clr_addr;
               ram_wdata <= BLANK;
               cnt <= (cnt == AW'(COLS-1)) ? '0 : cnt + 1'b1;
               state <= (cnt == AW'(COLS-1)) ? IDLE : CLEAR;
            end
            default: begin
               busy <= 1'b0;
               if (go) begin
                  cursor_x <= XW'(nx);
                  cursor_y <= YW'(ny);
                  if (store) begin
                     ram_we <= 1'b1;
                     ram_addr <= cur_addr;
                     ram_wdata <= par.Pchar;
                  end
                  // Scroll up clears the old top row, which becomes the new bottom line
                  if (up || down) begin
                     top_row <= up ? top_inc : top_dec;
                     clr_row <= up ? top_row : top_dec;
                     state <= CLEAR;
                     busy <= 1'b1;
                  end
               end
            end
         endcase
      end
endmodule

// File: tb/tb_command_executor.sv
// tb_command_executor: directed vector table plus scroll, pending-slot and reset sequences
module tb_command_executor;
   import command_executor_pkg::*;
   logic clk = 1'b0, rst = 1'b1, commandReady = 1'b0;
   CommandsType commandType = INPUT;
   Param_t param = '0;
   logic ram_we, busy, overflow;
   logic [10:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [6:0] cursor_x;
   logic [4:0] cursor_y, top_row;
   int checks = 0, errors = 0;

   typedef struct {
      CommandsType c;
      logic [7:0] pc, n1, n2;
      logic we;
      int addr;
      logic [7:0] data;
      int x, y;
   } vec_t;
   vec_t v[24];

   command_executor dut (
      .clk(clk), .rst(rst), .commandReady(commandReady), .commandType(commandType), .param(param),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .cursor_x(cursor_x),
      .cursor_y(cursor_y), .top_row(top_row), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input CommandsType c, input logic [7:0] pc, input logic [7:0] n1, input logic [7:0] n2);
      @(negedge clk);
      commandReady = 1'b1;
      commandType = c;
      param = '{Pchar: pc, Pn1: n1, Pn2: n2};
      @(negedge clk);
      commandReady = 1'b0;
   endtask

   task automatic run_fill(input string name, input int base, input int cnt);
      int w = 0, bad = 0;
      @(negedge clk);
      for (int i = 0; i < cnt + 20 && busy; i++) begin
         if (ram_we) begin
            if (int'(ram_addr) != base + w || ram_wdata != 8'h20) bad++;
            w++;
         end
         @(negedge clk);
      end
      check({name, " busy_end"}, busy, 0);
      check({name, " writes"}, w, cnt);
      check({name, " bad_cells"}, bad, 0);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 200 && busy; i++) @(negedge clk);
      check({name, " busy_end"}, busy, 0);
   endtask

   initial begin
      v[0]  = '{INPUT, 8'h41, 8'd0, 8'd0, 1'b1, 0, 8'h41, 1, 0};
      v[1]  = '{CUP, 8'h00, 8'd5, 8'd10, 1'b0, 0, 8'h00, 9, 4};
      v[2]  = '{CUU, 8'h00, 8'd0, 8'd0, 1'b0, 0, 8'h00, 9, 3};
      v[3]  = '{CUB, 8'h00, 8'd50, 8'd0, 1'b0, 0, 8'h00, 0, 3};
      v[4]  = '{CUP, 8'h00, 8'd0, 8'd200, 1'b0, 0, 8'h00, 79, 0};
      v[5]  = '{INPUT, 8'h08, 8'd0, 8'd0, 1'b0, 0, 8'h00, 78, 0};
      v[6]  = '{INPUT, 8'h0D, 8'd0, 8'd0, 1'b0, 0, 8'h00, 0, 0};
      v[7]  = '{CUF, 8'h00, 8'd0, 8'd0, 1'b0, 0, 8'h00, 1, 0};
      v[8]  = '{CUD, 8'h00, 8'd100, 8'd0, 1'b0, 0, 8'h00, 1, 24};
      v[9]  = '{CUU, 8'h00, 8'd30, 8'd0, 1'b0, 0, 8'h00, 1, 0};
      v[10] = '{INPUT, 8'h0A, 8'd0, 8'd0, 1'b0, 0, 8'h00, 1, 1};
      v[11] = '{INPUT, 8'h07, 8'd0, 8'd0, 1'b0, 0, 8'h00, 1, 1};
      v[12] = '{CommandsType'(4'd12), 8'h41, 8'd3, 8'd3, 1'b0, 0, 8'h00, 1, 1};
      v[13] = '{INPUT, 8'h62, 8'd0, 8'd0, 1'b1, 81, 8'h62, 2, 1};
      v[14] = '{CUF, 8'h00, 8'd255, 8'd0, 1'b0, 0, 8'h00, 79, 1};
      v[15] = '{NEL, 8'h00, 8'd0, 8'd0, 1'b0, 0, 8'h00, 0, 2};
      v[16] = '{IND, 8'h00, 8'd0, 8'd0, 1'b0, 0, 8'h00, 0, 3};
      v[17] = '{RI, 8'h00, 8'd0, 8'd0, 1'b0, 0, 8'h00, 0, 2};
      v[18] = '{CUP, 8'h00, 8'd30, 8'd1, 1'b0, 0, 8'h00, 0, 24};
      v[19] = '{INPUT, 8'h08, 8'd0, 8'd0, 1'b0, 0, 8'h00, 0, 24};
      v[20] = '{INPUT, 8'h7E, 8'd0, 8'd0, 1'b1, 1920, 8'h7E, 1, 24};
      v[21] = '{INPUT, 8'h7F, 8'd0, 8'd0, 1'b0, 0, 8'h00, 1, 24};
      v[22] = '{INPUT, 8'h20, 8'd0, 8'd0, 1'b1, 1921, 8'h20, 2, 24};
      v[23] = '{CUD, 8'h00, 8'd1, 8'd0, 1'b0, 0, 8'h00, 2, 24};

      repeat (3) @(negedge clk);
      check("rst ram_we", ram_we, 0);
      check("rst busy", busy, 1);
      check("rst overflow", overflow, 0);
      check("rst cursor", {cursor_x, cursor_y}, 0);
      check("rst top_row", top_row, 0);
      rst = 1'b0;
      run_fill("init", 0, 2000);
      check("init cursor", {cursor_x, cursor_y}, 0);
      check("init top_row", top_row, 0);

      foreach (v[i]) begin
         send(v[i].c, v[i].pc, v[i].n1, v[i].n2);
         check($sformatf("v%0d we", i), ram_we, v[i].we);
         if (v[i].we) begin
            check($sformatf("v%0d addr", i), ram_addr, v[i].addr);
            check($sformatf("v%0d data", i), ram_wdata, v[i].data);
         end
         check($sformatf("v%0d x", i), cursor_x, v[i].x);
         check($sformatf("v%0d y", i), cursor_y, v[i].y);
         check($sformatf("v%0d top", i), top_row, 0);
         check($sformatf("v%0d busy", i), busy, 0);
      end

      send(CUP, 8'h00, 8'd25, 8'd80);
      check("cup max x", cursor_x, 79);
      check("cup max y", cursor_y, 24);
      send(INPUT, 8'h5A, 8'd0, 8'd0);
      check("wrap we", ram_we, 1);
      check("wrap addr", ram_addr, 1999);
      check("wrap data", ram_wdata, 8'h5A);
      check("wrap x", cursor_x, 0);
      check("wrap y", cursor_y, 24);
      check("wrap top", top_row, 1);
      check("wrap busy", busy, 1);
      run_fill("scroll_up", 0, 80);
      send(INPUT, 8'h51, 8'd0, 8'd0);
      check("q addr", ram_addr, 0);
      check("q data", ram_wdata, 8'h51);
      check("q x", cursor_x, 1);

      send(CUP, 8'h00, 8'd1, 8'd1);
      send(RI, 8'h00, 8'd0, 8'd0);
      check("ri1 top", top_row, 0);
      check("ri1 y", cursor_y, 0);
      run_fill("ri1", 0, 80);
      send(RI, 8'h00, 8'd0, 8'd0);
      check("ri2 top", top_row, 24);
      run_fill("ri2", 1920, 80);

      send(CUP, 8'h00, 8'd1, 8'd11);
      send(RI, 8'h00, 8'd0, 8'd0);
      check("pend top", top_row, 23);
      send(CUF, 8'h00, 8'd3, 8'd0);
      check("pend held x", cursor_x, 10);
      check("pend busy", busy, 1);
      check("pend no overflow", overflow, 0);
      send(CUB, 8'h00, 8'd1, 8'd0);
      check("drop overflow", overflow, 1);
      wait_idle("pend");
      check("pend exec x", cursor_x, 13);
      send(CUD, 8'h00, 8'd2, 8'd0);
      check("after drop x", cursor_x, 13);
      check("after drop y", cursor_y, 2);
      check("overflow sticky", overflow, 1);

      send(CUP, 8'h00, 8'd1, 8'd1);
      send(RI, 8'h00, 8'd0, 8'd0);
      repeat (3) @(negedge clk);
      check("midclear we", ram_we, 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort we", ram_we, 0);
      check("abort busy", busy, 1);
      check("abort overflow", overflow, 0);
      check("abort top", top_row, 0);
      rst = 1'b0;
      run_fill("reinit", 0, 2000);
      check("reinit cursor", {cursor_x, cursor_y}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
